calc_seq_ctrl: RTL and testbench

- Parametrised successor of the calculator entry sequencer. Captures operand 1, operator and operand 2 as BCD digit streams from the keypad decoder.
- Requests the result from a multi-cycle ALU over a start/done handshake, supports chained operations, and shows the result.
- Adds an explicit ERR state and a digit-count limit. Sits between the keypad decoder and the ALU/display mux.

---
 rtl/calc_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_seq_ctrl : calculator entry sequencer, ALU start/done handshake, ERR  |
// |   state and per-operand digit limit. Optional: CALC_SEQ_BACKSPACE_EN       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module calc_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int OP_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_num,
  input  logic                is_op,
  input  logic                is_eq,
  input  logic                is_clr,
  input  logic                is_del,
  input  logic [3:0]          num_val,
  input  logic [OP_W-1:0]     op_val,
  input  logic [4*DIGITS-1:0] alu_result,
  input  logic                alu_done,
  input  logic                alu_err,
  output logic                alu_start,
  output logic [4*DIGITS-1:0] num1_bcd,
  output logic [4*DIGITS-1:0] num2_bcd,
  output logic [OP_W-1:0]     operation,
  output logic [2:0]          curr_state,
  output logic                entry_full,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DIGITS);

  typedef enum logic [2:0] {
    S_N1   = 3'd0,
    S_OP   = 3'd1,
    S_N2   = 3'd2,
    S_CALC = 3'd3,
    S_EQ   = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    num1_q, num1_d, num2_q, num2_d, shadow_q, shadow_d;
  logic [OP_W-1:0] op_q, op_d, pend_q, pend_d;
  logic [CW-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic            tgt_eq_q, tgt_eq_d;
  logic            alu_start_q, alu_start_d;
  logic            full_q, full_d;
  logic            err_q, err_d;

  logic [W-1:0]    act_val, app_val, first_val;
  logic [CW-1:0]   act_cnt, app_cnt, first_cnt;
  logic            digit_ok;

`ifdef CALC_SEQ_BACKSPACE_EN
  logic [W-1:0]    del_val;
  logic [CW-1:0]   del_cnt;
`else
  logic            unused_del;
  assign unused_del = is_del;
`endif

  // Candidate append result for whichever operand is being entered
  always_comb begin
    act_val   = (state_q == S_N2) ? num2_q : num1_q;
    act_cnt   = (state_q == S_N2) ? cnt2_q : cnt1_q;
    digit_ok  = (num_val <= 4'd9);
    first_val = W'(num_val);
    first_cnt = (num_val == 4'd0) ? CW'(0) : CW'(1);
    app_val   = act_val;
    app_cnt   = act_cnt;
    if (digit_ok && (act_cnt != C_FULL) && !((act_val == '0) && (num_val == 4'd0))) begin
      app_val = (act_val << 4) | W'(num_val);
      app_cnt = act_cnt + CW'(1);
    end
`ifdef CALC_SEQ_BACKSPACE_EN
    del_val = act_val >> 4;
    del_cnt = (act_cnt == '0) ? act_cnt : act_cnt - CW'(1);
`endif
  end

  always_comb begin
    state_d     = state_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    shadow_d    = shadow_q;
    op_d        = op_q;
    pend_d      = pend_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    tgt_eq_d    = tgt_eq_q;
    alu_start_d = 1'b0;

    if (is_clr) begin
      state_d = S_N1;
      num1_d  = '0;
      num2_d  = '0;
      op_d    = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
    end else begin
      case (state_q)
        S_N1: begin
          if (is_eq) begin
          end else if (is_op) begin
            op_d    = op_val;
            state_d = S_OP;
`ifdef CALC_SEQ_BACKSPACE_EN
          end else if (is_del) begin
            num1_d = del_val;
            cnt1_d = del_cnt;
`endif
          end else if (is_num) begin
            num1_d = app_val;
            cnt1_d = app_cnt;
          end
        end
        S_OP: begin
          if (is_eq) begin
          end else if (is_op) begin
            op_d = op_val;
          end else if (is_num && digit_ok) begin
            num2_d  = first_val;
            cnt2_d  = first_cnt;
            state_d = S_N2;
          end
        end
        S_N2: begin
          if (is_eq || is_op) begin
            // num2 is snapshotted so a repeated '=' can replay it
            shadow_d    = num2_q;
            tgt_eq_d    = is_eq;
            state_d     = S_CALC;
            alu_start_d = 1'b1;
            if (!is_eq) pend_d = op_val;
`ifdef CALC_SEQ_BACKSPACE_EN
          end else if (is_del) begin
            num2_d = del_val;
            cnt2_d = del_cnt;
`endif
          end else if (is_num) begin
            num2_d = app_val;
            cnt2_d = app_cnt;
          end
        end
        S_CALC: begin
          if (alu_done) begin
            if (alu_err) begin
              state_d = S_ERR;
            end else begin
              num1_d = alu_result;
              num2_d = '0;
              cnt2_d = '0;
              if (tgt_eq_q) begin
                state_d = S_EQ;
              end else begin
                op_d    = pend_q;
                state_d = S_OP;
              end
            end
          end
        end
        S_EQ: begin
          if (is_eq) begin
            num2_d      = shadow_q;
            tgt_eq_d    = 1'b1;
            state_d     = S_CALC;
            alu_start_d = 1'b1;
          end else if (is_op) begin
            op_d    = op_val;
            state_d = S_OP;
          end else if (is_num && digit_ok) begin
            num1_d  = first_val;
            cnt1_d  = first_cnt;
            num2_d  = '0;
            cnt2_d  = '0;
            state_d = S_N1;
          end
        end
        S_ERR: begin
          if (is_eq || is_op) begin
          end else if (is_num && digit_ok) begin
            num1_d  = first_val;
            cnt1_d  = first_cnt;
            num2_d  = '0;
            cnt2_d  = '0;
            state_d = S_N1;
          end
        end
        default: state_d = S_N1;
      endcase
    end

    full_d = ((state_d == S_N1) && (cnt1_d == C_FULL)) ||
             ((state_d == S_N2) && (cnt2_d == C_FULL));
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_N1;
      num1_q      <= '0;
      num2_q      <= '0;
      shadow_q    <= '0;
      op_q        <= '0;
      pend_q      <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      tgt_eq_q    <= 1'b0;
      alu_start_q <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      shadow_q    <= shadow_d;
      op_q        <= op_d;
      pend_q      <= pend_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      tgt_eq_q    <= tgt_eq_d;
      alu_start_q <= alu_start_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign alu_start  = alu_start_q;
  assign num1_bcd   = num1_q;
  assign num2_bcd   = num2_q;
  assign operation  = op_q;
  assign curr_state = state_q;
  assign entry_full = full_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_calc_seq_ctrl : bench for calc_seq_ctrl (decimal-value reference model) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_calc_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int OP_W   = 2;
  localparam int W      = 4 * DIGITS;
`ifdef CALC_SEQ_BACKSPACE_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif
  localparam int N1 = 0, OP = 1, N2 = 2, CALC = 3, EQ = 4, ERR = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            is_num = 0, is_op = 0, is_eq = 0, is_clr = 0, is_del = 0;
  logic [3:0]      num_val = '0;
  logic [OP_W-1:0] op_val = '0;
  logic [W-1:0]    alu_result = '0;
  logic            alu_done = 0, alu_err = 0;
  logic            alu_start;
  logic [W-1:0]    num1_bcd, num2_bcd;
  logic [OP_W-1:0] operation;
  logic [2:0]      curr_state;
  logic            entry_full, err;

  calc_seq_ctrl #(.DIGITS(DIGITS), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .is_num(is_num), .is_op(is_op), .is_eq(is_eq),
    .is_clr(is_clr), .is_del(is_del), .num_val(num_val), .op_val(op_val),
    .alu_result(alu_result), .alu_done(alu_done), .alu_err(alu_err),
    .alu_start(alu_start), .num1_bcd(num1_bcd), .num2_bcd(num2_bcd),
    .operation(operation), .curr_state(curr_state), .entry_full(entry_full),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  bit started = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: operands held as plain decimal integers
  int m_state = N1, m_n1 = 0, m_n2 = 0, m_shadow = 0;
  logic [OP_W-1:0] m_op = '0, m_pend = '0;
  bit m_tgt_eq = 0, m_start = 0;

  function automatic int ndig(input int v);
    int n = 0;
    while (v > 0) begin n++; v = v / 10; end
    return n;
  endfunction

  function automatic int append(input int v, input int d);
    if (d > 9 || ndig(v) >= DIGITS || (v == 0 && d == 0)) return v;
    return v * 10 + d;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [39:0] exp_vec();
    logic full;
    full = (m_state == N1 && ndig(m_n1) == DIGITS) || (m_state == N2 && ndig(m_n2) == DIGITS);
    return {m_start, to_bcd(m_n1), to_bcd(m_n2), m_op, 3'(m_state), full, (m_state == ERR)};
  endfunction

  always @(posedge clk) begin
    int s, n1, n2, sh, d;
    logic [OP_W-1:0] o, p;
    bit t, st;
    s = m_state; n1 = m_n1; n2 = m_n2; sh = m_shadow; o = m_op; p = m_pend; t = m_tgt_eq;
    st = 0;
    d = int'(num_val);
    if (!rst) begin
      s = N1; n1 = 0; n2 = 0; sh = 0; o = '0; p = '0; t = 0;
    end else if (is_clr) begin
      s = N1; n1 = 0; n2 = 0; o = '0;
    end else begin
      case (s)
        N1: if (is_eq) begin end
            else if (is_op) begin o = op_val; s = OP; end
            else if (BS && is_del) n1 = n1 / 10;
            else if (is_num) n1 = append(n1, d);
        OP: if (is_eq) begin end
            else if (is_op) o = op_val;
            else if (is_num && d <= 9) begin n2 = d; s = N2; end
        N2: if (is_eq || is_op) begin
              sh = n2; t = is_eq; s = CALC; st = 1;
              if (!is_eq) p = op_val;
            end
            else if (BS && is_del) n2 = n2 / 10;
            else if (is_num) n2 = append(n2, d);
        CALC: if (alu_done) begin
              if (alu_err) s = ERR;
              else begin
                n1 = from_bcd(alu_result); n2 = 0;
                if (t) s = EQ; else begin o = p; s = OP; end
              end
            end
        EQ: if (is_eq) begin n2 = sh; t = 1; s = CALC; st = 1; end
            else if (is_op) begin o = op_val; s = OP; end
            else if (is_num && d <= 9) begin n1 = d; n2 = 0; s = N1; end
        default: if (is_eq || is_op) begin end
            else if (is_num && d <= 9) begin n1 = d; n2 = 0; s = N1; end
      endcase
    end
    m_state <= s; m_n1 <= n1; m_n2 <= n2; m_shadow <= sh; m_op <= o; m_pend <= p;
    m_tgt_eq <= t; m_start <= st;
    started <= 1'b1;
  end

  wire [39:0] dut_vec = {alu_start, num1_bcd, num2_bcd, operation, curr_state, entry_full, err};

  always @(negedge clk) begin
    if (started) check("cycle", dut_vec, exp_vec());
    if (alu_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
    is_num = 0; is_op = 0; is_eq = 0; is_clr = 0; is_del = 0; alu_done = 0; alu_err = 0;
  endtask
  task automatic k_num(input logic [3:0] v); num_val = v; is_num = 1; tick(); endtask
  task automatic k_op(input logic [OP_W-1:0] v); op_val = v; is_op = 1; tick(); endtask
  task automatic k_eq(); is_eq = 1; tick(); endtask
  task automatic k_clr(); is_clr = 1; tick(); endtask
  task automatic k_del(); is_del = 1; tick(); endtask
  task automatic alu(input logic [W-1:0] r, input logic e);
    alu_result = r; alu_err = e; alu_done = 1; tick();
  endtask
  task automatic wait_start();
    int i = 0;
    while (alu_start !== 1'b1 && i < 20) begin tick(); i++; end
    n_tests++;
    if (alu_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_start: alu_start got %b required 1 within 20 cycles", alu_start);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 0; tick(); tick(); rst = 1;
    check("reset outputs", dut_vec, 40'd0);

    // 12 + 34 = with ALU answering 3 cycles after start
    base = start_cnt;
    k_num(1); k_num(2); k_op(2'd0); k_num(3); k_num(4); k_eq();
    wait_start(); tick(); tick(); alu(16'h0046, 0); tick();
    check("add state", 40'(curr_state), 40'(EQ));
    check("add num1", 40'(num1_bcd), 40'h0046);
    check("add num2", 40'(num2_bcd), 40'h0);
    check("add op", 40'(operation), 40'h0);
    check("add start pulses", 40'(start_cnt - base), 40'd1);

    // digit limit and leading zeros
    k_clr(); k_num(1); k_num(2); k_num(3); k_num(4); k_num(5);
    check("limit num1", 40'(num1_bcd), 40'h1234);
    check("limit full", 40'(entry_full), 40'd1);
    k_clr(); k_num(0); k_num(0); k_num(7);
    check("lead0 num1", 40'(num1_bcd), 40'h0007);
    check("lead0 full", 40'(entry_full), 40'd0);
    k_num(1); k_num(2); k_num(3); k_num(9);
    check("lead0 fill", 40'(num1_bcd), 40'h7123);
    k_clr(); k_num(1); k_num(4'hA);
    check("bad digit", 40'(num1_bcd), 40'h0001);

    // chaining; first ALU done lands in the same cycle as alu_start
    k_clr(); k_num(5); k_op(2'd0); k_num(3); k_op(2'd0);
    wait_start(); alu(16'h0008, 0);
    check("chain state", 40'(curr_state), 40'(OP));
    check("chain num1", 40'(num1_bcd), 40'h0008);
    k_num(2); k_eq();
    check("chain calc", {5'b0, alu_start, num1_bcd, num2_bcd, 3'b0}, {5'b0, 1'b1, 16'h0008, 16'h0002, 3'b0});
    check("chain cstate", 40'(curr_state), 40'(CALC));
    tick(); alu(16'h0010, 0);
    k_eq();
    check("repeat num2", 40'(num2_bcd), 40'h0002);
    alu(16'h0012, 0);
    check("repeat num1", 40'(num1_bcd), 40'h0012);

    // divide by zero
    k_clr(); k_num(9); k_op(2'd3); k_num(0); k_eq();
    wait_start(); tick(); alu(16'h0000, 1);
    check("err state", 40'(curr_state), 40'(ERR));
    check("err flag", 40'(err), 40'd1);
    k_op(2'd1); k_eq();
    check("err hold", 40'(curr_state), 40'(ERR));
    k_num(4);
    check("err exit", {curr_state, num1_bcd, err}, {3'(N1), 16'h0004, 1'b0});

    // reset during CALC then a late done
    k_clr(); k_num(1); k_op(2'd1); k_num(2); k_eq();
    rst = 0; tick(); rst = 1;
    base = start_cnt;
    alu(16'h0003, 0); tick();
    check("rst calc", dut_vec, 40'd0);
    check("rst no start", 40'(start_cnt - base), 40'd0);
    k_num(3); k_op(2'd2); k_num(4);
    is_clr = 1; num_val = 4'd6; is_num = 1; tick();
    check("clr+num", dut_vec, 40'd0);

    // delete key
    k_clr(); k_num(1); k_num(2); k_num(3); k_del();
    check("del num1", 40'(num1_bcd), BS ? 40'h0012 : 40'h0123);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
